// File: rtl/raifes_uart_pkg.sv
// Shared UART constants and state encoding for the raifes transmitter and receiver.
package raifes_uart_pkg;

  localparam int DATA_W           = 8;
  localparam int CLKS_PER_BIT_DEF = 217;

  // Mid-bit offset used to land the first sample in the centre of the start bit.
  function automatic int half_bit(input int cpb);
    return (cpb - 1) / 2;
  endfunction

  localparam int HALF_BIT_DEF = half_bit(CLKS_PER_BIT_DEF);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } uart_state_e;

endpackage

// File: rtl/raifes_uart_rx_if.sv
// Receive-side peripheral bus: FWFT byte stream with read strobe plus sticky error flags.
interface raifes_uart_rx_if;

  logic [raifes_uart_pkg::DATA_W-1:0] rdata;
  logic                               rvalid;
  logic                               read_strobe;
  logic                               frame_err;
  logic                               overrun;
  logic                               err_clear;

  modport master (
    output rdata, rvalid, frame_err, overrun,
    input  read_strobe, err_clear
  );

  modport slave (
    input  rdata, rvalid, frame_err, overrun,
    output read_strobe, err_clear
  );

endinterface

// File: rtl/raifes_uart_rx_fifo.sv
// First-word-fall-through FIFO: rdata is the registered head entry, push/pop take effect next edge.
// A pop on empty is ignored; a push on full is accepted only alongside a pop.
module raifes_uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/raifes_uart_rx.sv
// 8N1 UART receiver: mid-bit sampling via a down-counting bit timer, bytes land in an FWFT FIFO.
// Byte visible 2063 clocks after the start edge is seen; a byte finishing into a full FIFO is dropped and flagged.
module raifes_uart_rx
  import raifes_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              UART_RX,
  raifes_uart_rx_if.master  bus
);

  localparam int            TW        = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_LOAD  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LOAD = TW'(half_bit(CLKS_PER_BIT));

  logic [1:0]        sync_q, sync_d;
  uart_state_e       state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              rx_s, tick, push, frame_set, overrun_set;
  logic              fifo_empty, fifo_full;

  assign rx_s   = sync_q[1];
  assign tick   = (timer_q == '0);
  assign sync_d = {sync_q[0], UART_RX};

  always_comb begin
    state_d   = state_q;
    timer_d   = tick ? timer_q : timer_q - 1'b1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;
    unique case (state_q)
      ST_IDLE: if (!rx_s) begin
        state_d = ST_START;
        timer_d = HALF_LOAD;
      end
      ST_START: if (tick) begin
        state_d   = rx_s ? ST_IDLE : ST_DATA;
        timer_d   = BIT_LOAD;
        bit_cnt_d = '0;
      end
      ST_DATA: if (tick) begin
        shift_d   = {rx_s, shift_q[DATA_W-1:1]};
        timer_d   = BIT_LOAD;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == 3'd7) state_d = ST_STOP;
      end
      // Returning to IDLE at mid-stop lets a back-to-back start edge be caught.
      ST_STOP: if (tick) begin
        push      = rx_s;
        frame_set = !rx_s;
        state_d   = rx_s ? ST_IDLE : ST_WAIT_HIGH;
      end
      ST_WAIT_HIGH: if (rx_s) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A full FIFO with a same-cycle read still has room, so only an unread full FIFO overruns.
    overrun_set = push && fifo_full && !bus.read_strobe;
    frame_err_d = frame_set   || (frame_err_q && !bus.err_clear);
    overrun_d   = overrun_set || (overrun_q   && !bus.err_clear);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q      <= 2'b11;
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  raifes_uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (shift_q),
    .pop   (bus.read_strobe),
    .rdata (bus.rdata),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign bus.rvalid    = !fifo_empty;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_raifes_uart_rx.sv
// Bench for raifes_uart_rx: vector table, hand-written corner sequences, randomized frames vs a queue model.
module tb_raifes_uart_rx;

  localparam int CPB   = 217;
  localparam int DEPTH = 4;

  logic clk     = 1'b0;
  logic reset   = 1'b1;
  logic uart_rx = 1'b1;

  raifes_uart_rx_if bus();

  raifes_uart_rx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .UART_RX (uart_rx),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    bit         stop_hi;
    int         period;
    bit         exp_vld;
    logic [7:0] exp_dat;
    bit         exp_ferr;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Serialises start, 8 data bits LSB first and the stop bit; a low stop bit may be stretched into a break.
  task automatic send_frame(input logic [7:0] d, input bit stop_hi, input int period, input int low_hold);
    logic [9:0] bits;
    bits = {stop_hi, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = bits[i];
      repeat (period) step();
    end
    if (!stop_hi) repeat (low_hold) step();
    uart_rx = 1'b1;
    if (!stop_hi) repeat (4) step();
  endtask

  task automatic pop();
    bus.read_strobe = 1'b1;
    step();
    bus.read_strobe = 1'b0;
  endtask

  task automatic clear_errs();
    bus.err_clear = 1'b1;
    step();
    bus.err_clear = 1'b0;
  endtask

  initial begin
    vec_t       vecs [5];
    int         cnt;
    logic [7:0] mq [$];
    bit         m_ferr, m_ovr, stop;
    logic [7:0] d;
    int         per, nrd;

    vecs[0] = '{8'h96, 1'b1, 211, 1'b1, 8'h96, 1'b0};
    vecs[1] = '{8'h96, 1'b1, 223, 1'b1, 8'h96, 1'b0};
    vecs[2] = '{8'h00, 1'b1, CPB, 1'b1, 8'h00, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, CPB, 1'b1, 8'hFF, 1'b0};
    vecs[4] = '{8'h5A, 1'b0, CPB, 1'b0, 8'h00, 1'b1};

    bus.read_strobe = 1'b0;
    bus.err_clear   = 1'b0;
    repeat (3) step();
    chk("reset_rvalid", int'(bus.rvalid), 0);
    chk("reset_rdata", int'(bus.rdata), 0);
    chk("reset_frame_err", int'(bus.frame_err), 0);
    chk("reset_overrun", int'(bus.overrun), 0);
    reset = 1'b0;
    step();

    // Latency from pin falling edge to rvalid
    cnt = 0;
    fork
      send_frame(8'h55, 1'b1, CPB, 0);
      begin
        while (bus.rvalid !== 1'b1 && cnt < 3000) begin
          step();
          cnt++;
        end
      end
    join
    chk("t1_latency", cnt, 2065);
    chk("t1_rdata", int'(bus.rdata), 8'h55);
    pop();
    chk("t1_rvalid_after_pop", int'(bus.rvalid), 0);

    // Short low glitch is rejected at the start-bit sample
    uart_rx = 1'b0;
    repeat (50) step();
    uart_rx = 1'b1;
    repeat (150) step();
    chk("t2_rvalid", int'(bus.rvalid), 0);
    chk("t2_frame_err", int'(bus.frame_err), 0);

    foreach (vecs[i]) begin
      send_frame(vecs[i].data, vecs[i].stop_hi, vecs[i].period, 0);
      step();
      chk($sformatf("vec%0d_rvalid", i), int'(bus.rvalid), int'(vecs[i].exp_vld));
      if (vecs[i].exp_vld) chk($sformatf("vec%0d_rdata", i), int'(bus.rdata), int'(vecs[i].exp_dat));
      chk($sformatf("vec%0d_frame_err", i), int'(bus.frame_err), int'(vecs[i].exp_ferr));
      pop();
      clear_errs();
      chk($sformatf("vec%0d_drained", i), int'(bus.rvalid), 0);
      chk($sformatf("vec%0d_cleared", i), int'(bus.frame_err), 0);
    end

    // Bad stop bit followed by a 5-bit break, then a clean frame
    send_frame(8'hA5, 1'b0, CPB, 5 * CPB);
    chk("t3_frame_err", int'(bus.frame_err), 1);
    chk("t3_no_byte", int'(bus.rvalid), 0);
    send_frame(8'h3C, 1'b1, CPB, 0);
    step();
    chk("t3_rvalid", int'(bus.rvalid), 1);
    chk("t3_rdata", int'(bus.rdata), 8'h3C);
    chk("t3_frame_err_sticky", int'(bus.frame_err), 1);
    pop();
    chk("t3_only_one", int'(bus.rvalid), 0);
    clear_errs();
    chk("t3_cleared", int'(bus.frame_err), 0);

    // Five back-to-back bytes into a 4-deep FIFO
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, CPB, 0);
    step();
    chk("t4_overrun", int'(bus.overrun), 1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("t4_read%0d", i), int'(bus.rdata), i);
      pop();
    end
    chk("t4_empty", int'(bus.rvalid), 0);
    clear_errs();
    chk("t4_ovr_cleared", int'(bus.overrun), 0);

    // Refill, then pop exactly on the push cycle of the fifth byte
    for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b1, CPB, 0);
    fork
      send_frame(8'h15, 1'b1, CPB, 0);
      begin
        repeat (2064) step();
        bus.read_strobe = 1'b1;
        step();
        bus.read_strobe = 1'b0;
      end
    join
    chk("t4_no_overrun", int'(bus.overrun), 0);
    for (int i = 2; i <= 4; i++) begin
      chk($sformatf("t4_refill%0d", i), int'(bus.rdata), 8'h10 + i);
      pop();
    end
    chk("t4_last_kept", int'(bus.rdata), 8'h15);
    chk("t4_last_valid", int'(bus.rvalid), 1);

    // Asynchronous reset mid data bit 4, held until the aborted frame ends
    fork
      send_frame(8'hC3, 1'b1, CPB, 0);
      begin
        repeat (1150) step();
        reset = 1'b1;
        #1;
        chk("t5_rvalid_async", int'(bus.rvalid), 0);
        chk("t5_rdata_async", int'(bus.rdata), 0);
        chk("t5_frame_err_async", int'(bus.frame_err), 0);
        chk("t5_overrun_async", int'(bus.overrun), 0);
      end
    join
    step();
    reset = 1'b0;
    step();
    send_frame(8'hC3, 1'b1, CPB, 0);
    step();
    chk("t5_rvalid", int'(bus.rvalid), 1);
    chk("t5_rdata", int'(bus.rdata), 8'hC3);
    pop();
    repeat (50) step();
    chk("t5_once", int'(bus.rvalid), 0);

    // Random frames, reads and clears against a queue model of FIFO + flags
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    for (int n = 0; n < 8; n++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 4) != 0);
      per  = $urandom_range(213, 221);
      send_frame(d, stop, per, stop ? 0 : $urandom_range(0, 300));
      step();
      if (!stop) m_ferr = 1'b1;
      else if (mq.size() == DEPTH) m_ovr = 1'b1;
      else mq.push_back(d);
      chk($sformatf("rnd%0d_frame_err", n), int'(bus.frame_err), int'(m_ferr));
      chk($sformatf("rnd%0d_overrun", n), int'(bus.overrun), int'(m_ovr));
      chk($sformatf("rnd%0d_rvalid", n), int'(bus.rvalid), int'(mq.size() != 0));
      nrd = $urandom_range(0, 2);
      for (int k = 0; k < nrd; k++) begin
        if (mq.size() != 0) begin
          chk($sformatf("rnd%0d_rdata%0d", n, k), int'(bus.rdata), int'(mq[0]));
          void'(mq.pop_front());
        end
        pop();
      end
      chk($sformatf("rnd%0d_rvalid_post", n), int'(bus.rvalid), int'(mq.size() != 0));
      if ($urandom_range(0, 2) == 0) begin
        clear_errs();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/raifes_uart_rx.md
Name: raifes_uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart to the existing raifes_uart transmitter.
- Samples the asynchronous UART_RX pin at mid-bit using a bit timer and assembles bytes LSB first.
- Delivers bytes through a small first-word-fall-through FIFO with a valid/read-strobe handshake toward the core's peripheral bus.
- Default timing: 25 MHz clock, 115200 baud.

Parameters:
- CLKS_PER_BIT, 217, clocks per bit (25 MHz / 115200 baud); legal values are ≥ 4.
- FIFO_DEPTH, 4, receive FIFO entries; must be a power of two, ≥ 2.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- UART_RX  in  1  serial input pin, asynchronous, idle high
- rdata  out  8  head-of-FIFO byte; valid only while rvalid=1
- rvalid  out  1  FIFO not empty
- read_strobe  in  1  pop head byte; ignored when rvalid=0
- frame_err  out  1  sticky: stop bit sampled low
- overrun  out  1  sticky: byte completed while FIFO full, byte dropped
- err_clear  in  1  clears frame_err and overrun

Behaviour:
- **Interface:** one clock. Reset is asynchronous, active-high, and forces every register to its reset value immediately, including mid-frame.
- **Reset values:** rvalid=0, rdata=0, frame_err=0, overrun=0, FIFO empty, state IDLE, synchroniser flops=1.
- **Input synchroniser:** UART_RX passes through 2 flops to give rx_s. All decisions use rx_s.
- **Bit timer:** down-counter; "tick" when it equals 0. States load the timer as listed below.
- **FSM state IDLE:** on rx_s=0, go to START and load timer=(CLKS_PER_BIT-1)/2, i.e. 108.
- **FSM state START:** on tick, sample rx_s.
  - Sample 0: go to DATA, timer=CLKS_PER_BIT-1, bit_cnt=0.
  - Sample 1 (glitch): go to IDLE, with no flags and no push.
- **FSM state DATA:** on each tick, shift rx_s into the MSB of an 8-bit shift register (shift right), reload the timer, and increment bit_cnt. After the 8th sample, go to STOP.
- **FSM state STOP:** on tick, sample rx_s.
  - Sample 1: push the byte and go to IDLE.
  - Sample 0: set frame_err, discard the byte, go to WAIT_HIGH.
- **FSM state WAIT_HIGH:** stay until rx_s=1, then go to IDLE. This prevents a break condition from retriggering reception.
- **Latency:** let t0 be the first clock at which IDLE sees rx_s=0.
  - Start-bit sample at t0+109.
  - Data bit k sample at t0+109+217·k, for k=1..8.
  - Stop-bit sample at t0+2062.
  - rvalid/rdata update at t0+2063.
  - The receiver re-arms at mid-stop-bit, so back-to-back frames are accepted.
- **FIFO:** FWFT. rdata equals the head entry combinationally from registered storage; rvalid = count≠0.
  - Pointers wrap modulo FIFO_DEPTH; count width is log2(FIFO_DEPTH)+1.
  - Push while full with no pop in the same cycle: set overrun, drop the new byte, keep FIFO contents.
  - Push and pop in the same cycle while full: both occur, no overrun.
  - Push and pop in the same cycle while empty: only the push occurs (the pop is ignored because rvalid=0).
- **Sticky flags:** cleared by err_clear. A set event in the same cycle as err_clear wins, so the flag stays 1.
- **Error independence:** frame_err and overrun do not block reception.

Decomposition:
- **Package raifes_uart_pkg**, shared with the transmitter:
  - Default CLKS_PER_BIT (217) and the derived half-bit constant.
  - State encodings for IDLE/START/DATA/STOP/WAIT_HIGH.
  - Data width constant 8.
- **Sub-module raifes_uart_rx_fifo:**
  - Parameterised by depth and width.
  - Ports: push, wdata, pop, rdata, empty, full.
  - Overrun detection stays in the top level.

Test Plan:
1. Drive 0x55 at 217 clk/bit, 8N1 → rvalid rises 2065 clocks after the pin falling edge (2 synchroniser clocks + 2063); rdata=0x55; pulse read_strobe → rvalid=0.
2. Pull the pin low for 50 clocks, then high → no rvalid, frame_err=0, FSM returns to IDLE.
3. Send 0xA5 with stop bit low, then hold the line low for 5 bit times, then release and send 0x3C → frame_err=1, FIFO holds only 0x3C; err_clear → frame_err=0.
4. Send 0x01..0x05 back-to-back with no reads (depth 4) → reads return 0x01,0x02,0x03,0x04 and overrun=1. Then refill to full and assert read_strobe on the push cycle of a 5th byte → no overrun, last byte retained.
5. Assert reset during data bit 4 → rvalid=0, flags=0 immediately; after release, send 0xC3 → 0xC3 is received exactly once.
6. Send 0x96 with transmitter bit periods of 211 and 223 clocks (±2.8%) → 0x96 received correctly, frame_err=0 in both runs.
